// File: rtl/fpu_ret_queue.sv
// fpu_ret_queue: in-order FIFO of FP unit exception-return reports plus sticky FP status flags
module fpu_ret_queue #(
  parameter int DEPTH = 8,
  parameter int AFULL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [13:0]              u1_ret,
  input  logic                     u1_ret_en,
  input  logic [10:0]              u1_flags,
  input  logic [13:0]              u2_ret,
  input  logic                     u2_ret_en,
  input  logic [10:0]              u2_flags,
  output logic [13:0]              out_ret,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [10:0]              sticky_flags,
  input  logic                     sticky_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [13:0]   mem [DEPTH];
  logic [AW:0]   wPtr, rPtr, nextCount;
  logic [AW+1:0] free;
  logic          pop, acc1, acc2, drop;
  logic [1:0]    pushN;
  logic [AW-1:0] slot2;
  always_comb begin
    count     = wPtr - rPtr;
    out_valid = count != '0;
    out_ret   = out_valid ? mem[rPtr[AW-1:0]] : 14'h0;
    pop       = out_valid & out_ready;
    free      = (AW+2)'(DEPTH) - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    acc1      = u1_ret_en && free >= (AW+2)'(1);
    // u2 needs a second slot only when u1 took one this cycle
    acc2      = u2_ret_en && free >= (acc1 ? (AW+2)'(2) : (AW+2)'(1));
    drop      = (u1_ret_en & ~acc1) | (u2_ret_en & ~acc2);
    pushN     = {1'b0, acc1} + {1'b0, acc2};
    slot2     = wPtr[AW-1:0] + {{(AW-1){1'b0}}, acc1};
    nextCount = flush ? '0 : count + {{(AW-1){1'b0}}, pushN} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && acc1) mem[wPtr[AW-1:0]] <= u1_ret;
    if (!rst && !flush && acc2) mem[slot2] <= u2_ret;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wPtr         <= '0;
      rPtr         <= '0;
      overflow     <= 1'b0;
      sticky_flags <= '0;
      almost_full  <= DEPTH <= AFULL;
    end else begin
      wPtr         <= flush ? '0 : wPtr + {{(AW-1){1'b0}}, pushN};
      rPtr         <= flush ? '0 : rPtr + {{AW{1'b0}}, pop};
      overflow     <= overflow | (drop & ~flush);
      sticky_flags <= (sticky_clr ? 11'h0 : sticky_flags)
                      | (u1_ret_en ? u1_flags : 11'h0) | (u2_ret_en ? u2_flags : 11'h0);
      almost_full  <= (DEPTH - int'(nextCount)) <= AFULL;
    end
  end
endmodule

// File: tb/tb_fpu_ret_queue.sv
// tb_fpu_ret_queue: directed-vector bench for fpu_ret_queue
module tb_fpu_ret_queue;
  logic        clk = 0, rst, flush, out_ready, sticky_clr;
  logic [13:0] u1_ret, u2_ret, out_ret;
  logic        u1_ret_en, u2_ret_en, out_valid, almost_full, overflow;
  logic [10:0] u1_flags, u2_flags, sticky_flags;
  logic [3:0]  count;
  int          nVec = 0, nMis = 0;

  fpu_ret_queue #(.DEPTH(8), .AFULL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .u1_ret(u1_ret), .u1_ret_en(u1_ret_en), .u1_flags(u1_flags),
    .u2_ret(u2_ret), .u2_ret_en(u2_ret_en), .u2_flags(u2_flags),
    .out_ret(out_ret), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .overflow(overflow),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; out_ready = 0; sticky_clr = 0;
    u1_ret = 0; u2_ret = 0; u1_ret_en = 0; u2_ret_en = 0; u1_flags = 0; u2_flags = 0;
    tick; tick;
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_valid", out_valid, 0);
      chk("idle_count", count, 0);
      chk("idle_sticky", sticky_flags, 0);
      chk("idle_ovf", overflow, 0);
      chk("idle_afull", almost_full, 0);
    end
    // dual push, then drain
    u1_ret = 14'h0011; u2_ret = 14'h0022; u1_ret_en = 1; u2_ret_en = 1; out_ready = 1;
    tick;
    u1_ret_en = 0; u2_ret_en = 0;
    chk("dual_cnt2", count, 2);
    chk("dual_head1", out_ret, 14'h0011);
    chk("dual_valid", out_valid, 1);
    tick;
    chk("dual_cnt1", count, 1);
    chk("dual_head2", out_ret, 14'h0022);
    tick;
    chk("dual_cnt0", count, 0);
    chk("dual_empty", out_valid, 0);
    chk("dual_ret0", out_ret, 0);
    // fill to full, then overflow
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      u1_ret = 14'h100 + 14'(i); u1_ret_en = 1;
      tick;
      chk("fill_cnt", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 6);
    end
    u1_ret = 14'h1FF;
    tick;
    u1_ret_en = 0;
    chk("full_cnt", count, 8);
    chk("full_ovf", overflow, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", out_ret, 14'h100 + 14'(i));
      tick;
    end
    chk("drain_cnt", count, 0);
    out_ready = 0;
    // full FIFO, pop + dual push: u1 in, u2 dropped
    rst = 1; tick; rst = 0;
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", count, 0);
    for (int i = 0; i < 8; i++) begin
      u1_ret = 14'h200 + 14'(i); u1_ret_en = 1;
      tick;
    end
    chk("refill_cnt", count, 8);
    chk("refill_ovf", overflow, 0);
    u1_ret = 14'h2AA; u2_ret = 14'h2BB; u2_ret_en = 1; out_ready = 1;
    tick;
    u1_ret_en = 0; u2_ret_en = 0;
    chk("popdual_cnt", count, 8);
    chk("popdual_ovf", overflow, 1);
    chk("popdual_head", out_ret, 14'h201);
    for (int i = 1; i < 8; i++) begin
      chk("popdual_data", out_ret, 14'h200 + 14'(i));
      tick;
    end
    chk("popdual_last", out_ret, 14'h2AA);
    tick;
    chk("popdual_done", count, 0);
    // sticky flags
    u1_ret_en = 1; u1_flags = 11'h001;
    tick;
    chk("stk_u1", sticky_flags, 11'h001);
    u1_ret_en = 0; u2_ret_en = 1; u2_flags = 11'h400;
    tick;
    chk("stk_u2", sticky_flags, 11'h401);
    u2_ret_en = 0; sticky_clr = 1; u1_ret_en = 1; u1_flags = 11'h002;
    tick;
    chk("stk_clr", sticky_flags, 11'h002);
    sticky_clr = 0; u1_ret_en = 0; u1_flags = 0; u2_flags = 0;
    tick; tick; tick;
    chk("stk_drain", count, 0);
    // flush with 5 entries
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      u1_ret = 14'h050 + 14'(i); u1_ret_en = 1;
      tick;
    end
    chk("pre_flush_cnt", count, 5);
    flush = 1; u1_flags = 11'h010; out_ready = 1;
    tick;
    flush = 0; u1_ret_en = 0; u1_flags = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", count, 0);
    chk("flush_ret", out_ret, 0);
    chk("flush_sticky", sticky_flags, 11'h012);
    chk("flush_ovf", overflow, 1);
    chk("flush_afull", almost_full, 0);
    // wrap: 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      u1_ret = 14'h300 + 14'(i); u1_ret_en = 1;
      tick;
      u1_ret_en = 0;
      chk("wrap_cnt1", count, 1);
      chk("wrap_data", out_ret, 14'h300 + 14'(i));
      tick;
      chk("wrap_cnt0", count, 0);
    end
    // full/empty still distinguished after wraps
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      u1_ret = 14'h3A0 + 14'(2 * i); u2_ret = 14'h3A1 + 14'(2 * i);
      u1_ret_en = 1; u2_ret_en = 1;
      tick;
    end
    u1_ret_en = 0; u2_ret_en = 0;
    chk("wrapfull_cnt", count, 8);
    chk("wrapfull_valid", out_valid, 1);
    chk("wrapfull_head", out_ret, 14'h3A0);
    chk("wrapfull_afull", almost_full, 1);
    rst = 1; tick; rst = 0;
    chk("midrst_cnt", count, 0);
    chk("midrst_valid", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
